// File: rtl/sr_latch_driver_if.sv
// Request/drive bundle between the command source and the SR latch front-end.
interface sr_latch_driver_if;
  logic set_req;
  logic rst_req;
  logic S;
  logic R;
  logic En;
  logic busy;
  logic state_q;
  logic conflict;
  logic overrun;

  modport slave (
    input  set_req, rst_req,
    output S, R, En, busy, state_q, conflict, overrun
  );

  modport master (
    output set_req, rst_req,
    input  S, R, En, busy, state_q, conflict, overrun
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Debounces raw set/reset requests and issues timed, mutually exclusive S/R pulses with En.
// Raw edge to pulse start is DB_CYCLES+3 cycles; no backpressure, repeat commands while pending raise overrun.
module sr_latch_driver #(
  parameter int DB_CYCLES    = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input logic             clk,
  input logic             rst,
  sr_latch_driver_if.slave bus
);

  // Zero is not a legal debounce or pulse length; it degrades to one cycle.
  localparam logic [7:0] DB_N    = (DB_CYCLES == 0)    ? 8'd1 : 8'(DB_CYCLES);
  localparam logic [7:0] PULSE_N = (PULSE_CYCLES == 0) ? 8'd1 : 8'(PULSE_CYCLES);
  localparam logic [7:0] GAP_N   = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  // Bit 0 is the set channel, bit 1 the reset channel.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] db;
  logic [1:0] db_d;
  logic [7:0] db_cnt [2];
  logic [1:0] rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_d   <= '0;
      db_cnt <= '{default: '0};
    end else begin
      sync1 <= {bus.rst_req, bus.set_req};
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_N - 8'd1) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = db & ~db_d;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] pend, pend_n, consume;
  logic       s_q, r_q, en_q, busy_q, q_q, conflict_q, ovr_q;
  logic       s_n, r_n, en_n, busy_n, q_n, conflict_n, ovr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      q_q        <= 1'b0;
      conflict_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      s_q        <= s_n;
      r_q        <= r_n;
      en_q       <= en_n;
      busy_q     <= busy_n;
      q_q        <= q_n;
      conflict_q <= conflict_n;
      ovr_q      <= ovr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    s_n        = s_q;
    r_n        = r_q;
    en_n       = en_q;
    q_n        = q_q;
    conflict_n = 1'b0;
    ovr_n      = ovr_q;
    consume    = 2'b00;
    case (state)
      IDLE: begin
        s_n  = 1'b0;
        r_n  = 1'b0;
        en_n = 1'b0;
        // Reset has priority; a simultaneous set is discarded and flagged.
        if (pend[1]) begin
          state_n = DRIVE;
          cnt_n   = PULSE_N - 8'd1;
          r_n     = 1'b1;
          en_n    = 1'b1;
          q_n     = 1'b0;
          consume = pend;
          if (pend[0]) begin
            conflict_n = 1'b1;
            ovr_n      = 1'b1;
          end
        end else if (pend[0]) begin
          state_n = DRIVE;
          cnt_n   = PULSE_N - 8'd1;
          s_n     = 1'b1;
          en_n    = 1'b1;
          q_n     = 1'b1;
          consume = 2'b01;
        end
      end
      DRIVE: begin
        if (cnt == 8'd0) begin
          s_n  = 1'b0;
          r_n  = 1'b0;
          en_n = 1'b0;
          if (GAP_N == 8'd0) begin
            state_n = IDLE;
          end else begin
            state_n = GAP;
            cnt_n   = GAP_N - 8'd1;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) state_n = IDLE;
        else             cnt_n   = cnt - 8'd1;
      end
      default: begin
        state_n = IDLE;
        s_n     = 1'b0;
        r_n     = 1'b0;
        en_n    = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
    // A flag being consumed this cycle can accept a fresh event without loss.
    pend_n = (pend & ~consume) | rise;
    if (|(rise & pend & ~consume)) ovr_n = 1'b1;
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.En       = en_q;
  assign bus.busy     = busy_q;
  assign bus.state_q  = q_q;
  assign bus.conflict = conflict_q;
  assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed timing cases plus randomized bouncing against a timeline model.
module tb_sr_latch_driver;

  localparam int DB = 4;
  localparam int P  = 2;
  localparam int G  = 1;

  logic clk;
  logic rst;
  sr_latch_driver_if bus ();

  sr_latch_driver #(.DB_CYCLES(DB), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: command timeline (start edge, kind) plus time-based debounce.
  int cyc = 0;
  int t0 = 0;
  int next_ok = 0;
  bit started = 0, kind_set = 0;
  bit s1s = 0, s2s = 0, s1r = 0, s2r = 0;
  bit db_s = 0, db_r = 0;
  int lm_s = 0, lm_r = 0;
  bit rise_s = 0, rise_r = 0;
  bit pend_s = 0, pend_r = 0;
  bit m_S = 0, m_R = 0, m_busy = 0, m_q = 0, m_conf = 0, m_ovr = 0;

  always @(posedge clk) begin
    bit cs, cr, nr_s, nr_r;
    int d;
    cyc++;
    if (rst) begin
      s1s = 0; s2s = 0; s1r = 0; s2r = 0;
      db_s = 0; db_r = 0; lm_s = cyc; lm_r = cyc;
      rise_s = 0; rise_r = 0; pend_s = 0; pend_r = 0;
      started = 0; next_ok = cyc + 1;
      m_q = 0; m_conf = 0; m_ovr = 0;
    end else begin
      cs = 0; cr = 0; m_conf = 0;
      if (cyc >= next_ok && (pend_s || pend_r)) begin
        started  = 1;
        t0       = cyc;
        kind_set = !pend_r;
        m_q      = kind_set;
        if (pend_s && pend_r) begin
          m_conf = 1;
          m_ovr  = 1;
        end
        cs = pend_s;
        cr = pend_r;
        next_ok = cyc + P + G + 1;
      end
      if (rise_s && pend_s && !cs) m_ovr = 1;
      if (rise_r && pend_r && !cr) m_ovr = 1;
      pend_s = (pend_s && !cs) || rise_s;
      pend_r = (pend_r && !cr) || rise_r;
      // Level flips once the sample has disagreed for DB edges since the last agreement.
      nr_s = 0;
      if (s2s == db_s) lm_s = cyc;
      else if (cyc - lm_s >= DB) begin db_s = s2s; lm_s = cyc; nr_s = s2s; end
      nr_r = 0;
      if (s2r == db_r) lm_r = cyc;
      else if (cyc - lm_r >= DB) begin db_r = s2r; lm_r = cyc; nr_r = s2r; end
      rise_s = nr_s;
      rise_r = nr_r;
      s2s = s1s; s1s = bus.set_req;
      s2r = s1r; s1r = bus.rst_req;
    end
    d = cyc - t0;
    m_S    = started && d < P && kind_set;
    m_R    = started && d < P && !kind_set;
    m_busy = started && d < P + G;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("S", bus.S, m_S);
      chk("R", bus.R, m_R);
      chk("En", bus.En, m_S | m_R);
      chk("busy", bus.busy, m_busy);
      chk("state_q", bus.state_q, m_q);
      chk("conflict", bus.conflict, m_conf);
      chk("overrun", bus.overrun, m_ovr);
      chk("s_and_r", bus.S & bus.R, 0);
      chk("en_eq_s_or_r", bus.En, bus.S | bus.R);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int saw_s, saw_r, n_conf, conf_e, last_s, first_r;
    rst = 1'b1;
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;
    do_reset();
    mon_on = 1'b1;
    chk("reset_S", bus.S, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_state_q", bus.state_q, 0);
    chk("reset_overrun", bus.overrun, 0);

    // Clean set held from edge 0: pulse on edges 7-8, gap on 9.
    bus.set_req = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      chk("t1_S", bus.S, (e == 7 || e == 8) ? 1 : 0);
      chk("t1_En", bus.En, (e == 7 || e == 8) ? 1 : 0);
      chk("t1_busy", bus.busy, (e >= 7 && e <= 9) ? 1 : 0);
      chk("t1_state_q", bus.state_q, (e >= 7) ? 1 : 0);
      chk("t1_model_S", m_S, (e == 7 || e == 8) ? 1 : 0);
      chk("t1_model_busy", m_busy, (e >= 7 && e <= 9) ? 1 : 0);
    end
    bus.set_req = 1'b0;
    repeat (10) step();

    // Short glitch never reaches the debounced level.
    do_reset();
    bus.set_req = 1'b1;
    repeat (3) step();
    bus.set_req = 1'b0;
    saw_s = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      saw_s |= bus.S;
    end
    chk("t2_no_S", saw_s, 0);
    chk("t2_state_q", bus.state_q, 0);

    // Simultaneous requests: reset wins, conflict on the entry edge, set lost.
    do_reset();
    bus.set_req = 1'b1;
    bus.rst_req = 1'b1;
    saw_s = 0; saw_r = 0; n_conf = 0; conf_e = -1;
    for (int e = 0; e < 14; e++) begin
      step();
      saw_s |= bus.S;
      saw_r |= bus.R;
      if (bus.conflict) begin
        n_conf++;
        conf_e = e;
      end
    end
    chk("t3_no_S", saw_s, 0);
    chk("t3_saw_R", saw_r, 1);
    chk("t3_conflict_cycles", n_conf, 1);
    chk("t3_conflict_edge", conf_e, 7);
    chk("t3_overrun", bus.overrun, 1);
    chk("t3_state_q", bus.state_q, 0);
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;
    repeat (10) step();
    chk("t3_overrun_sticky", bus.overrun, 1);

    // Reset request arriving during a set pulse is served after gap and idle.
    do_reset();
    bus.set_req = 1'b1;
    repeat (3) step();
    bus.rst_req = 1'b1;
    last_s = -1; first_r = -1;
    for (int e = 3; e <= 18; e++) begin
      step();
      if (bus.S) last_s = e;
      if (bus.R && first_r < 0) first_r = e;
    end
    chk("t4_last_S", last_s, 8);
    chk("t4_first_R", first_r, 11);
    chk("t4_state_q", bus.state_q, 0);
    chk("t4_overrun", bus.overrun, 0);
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;
    repeat (10) step();

    // Synchronous reset in the second pulse cycle kills the command.
    do_reset();
    bus.set_req = 1'b1;
    repeat (9) step();
    chk("t5_S_before", bus.S, 1);
    rst = 1'b1;
    bus.set_req = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_S", bus.S, 0);
    chk("t5_En", bus.En, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_state_q", bus.state_q, 0);
    chk("t5_overrun", bus.overrun, 0);
    repeat (10) step();

    // Random bouncing on both lines with occasional resets.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.set_req = ~bus.set_req;
      if ($urandom_range(0, 7) == 0) bus.rst_req = ~bus.rst_req;
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
